// File: rtl/cache_controller.sv
// CPU-side sequencer for a 2-way, 16-set, 4-word/line write-back cache: compare, writeback, refill, retry.
// Optional build macro CACHE_CTRL_STATS_EN adds saturating hit/miss/writeback counters.
module cache_controller #(
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 4,
  parameter int WORD_W  = 2,
  parameter int DATA_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req,
  input  logic                            cpu_write,
  input  logic [TAG_W+INDEX_W+WORD_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic [DATA_W-1:0]               cpu_rdata,
  output logic                            cpu_ready,
  output logic                            cache_enable,
  output logic                            cache_cmp,
  output logic                            cache_write,
  output logic [TAG_W-1:0]                cache_tag,
  output logic [INDEX_W-1:0]              cache_index,
  output logic [WORD_W-1:0]               cache_word,
  output logic [DATA_W-1:0]               cache_data_in,
  output logic                            cache_valid_in,
  input  logic                            cache_hit,
  input  logic                            cache_dirty,
  input  logic [TAG_W-1:0]                cache_tag_out,
  input  logic [DATA_W-1:0]               cache_data_out,
  input  logic                            cache_valid,
  input  logic                            cache_ack,
`ifdef CACHE_CTRL_STATS_EN
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count,
  output logic [15:0]                     wb_count,
`endif
  output logic                            mem_req,
  output logic                            mem_write,
  output logic [TAG_W+INDEX_W+WORD_W-1:0] mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_ack
);

  localparam int AW = TAG_W + INDEX_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_W = {WORD_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_WB_RD, S_WB_MEM, S_FL_MEM, S_FL_WR, S_DONE
  } state_t;

  state_t              state, state_n;
  logic                req_write;
  logic [TAG_W-1:0]    req_tag, victim_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [WORD_W-1:0]   req_word, w;
  logic [DATA_W-1:0]   req_wdata, buf_data, rdata_q;
  logic                gap, first_cmp;
  logic                in_cache_st, acc_done, hit_ok, wb_need;

  // gap forces one idle enable cycle after every completed cache access
  assign in_cache_st = (state == S_CMP) || (state == S_WB_RD) || (state == S_FL_WR);
  assign acc_done    = cache_enable && cache_ack;
  assign hit_ok      = cache_hit && cache_valid;
  assign wb_need     = cache_valid && cache_dirty;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (cpu_req) state_n = S_CMP;
      S_CMP:    if (acc_done) begin
                  if (hit_ok)       state_n = S_DONE;
                  else if (wb_need) state_n = S_WB_RD;
                  else              state_n = S_FL_MEM;
                end
      S_WB_RD:  if (acc_done) state_n = S_WB_MEM;
      S_WB_MEM: if (mem_ack)  state_n = (w == LAST_W) ? S_FL_MEM : S_WB_RD;
      S_FL_MEM: if (mem_ack)  state_n = S_FL_WR;
      S_FL_WR:  if (acc_done) state_n = (w == LAST_W) ? S_CMP : S_FL_MEM;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_write  <= 1'b0;
      req_tag    <= '0;
      req_index  <= '0;
      req_word   <= '0;
      req_wdata  <= '0;
      victim_tag <= '0;
      w          <= '0;
      buf_data   <= '0;
      rdata_q    <= '0;
      gap        <= 1'b0;
      first_cmp  <= 1'b0;
    end else begin
      gap <= acc_done;
      unique case (state)
        S_IDLE: if (cpu_req) begin
          req_write <= cpu_write;
          req_tag   <= cpu_addr[AW-1 -: TAG_W];
          req_index <= cpu_addr[WORD_W +: INDEX_W];
          req_word  <= cpu_addr[WORD_W-1:0];
          req_wdata <= cpu_wdata;
          first_cmp <= 1'b1;
        end
        S_CMP: if (acc_done) begin
          first_cmp <= 1'b0;
          if (hit_ok) begin
            rdata_q <= req_write ? '0 : cache_data_out;
          end else begin
            w <= '0;
            if (wb_need) victim_tag <= cache_tag_out;
          end
        end
        S_WB_RD:  if (acc_done) buf_data <= cache_data_out;
        S_WB_MEM: if (mem_ack) w <= (w == LAST_W) ? '0 : w + WORD_W'(1);
        S_FL_MEM: if (mem_ack) buf_data <= mem_rdata;
        S_FL_WR:  if (acc_done) w <= (w == LAST_W) ? '0 : w + WORD_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so they are steady for the whole wait on an ack
  always_comb begin
    cpu_rdata      = '0;
    cpu_ready      = 1'b0;
    cache_enable   = in_cache_st && !gap;
    cache_cmp      = 1'b0;
    cache_write    = 1'b0;
    cache_tag      = '0;
    cache_index    = '0;
    cache_word     = '0;
    cache_data_in  = '0;
    cache_valid_in = 1'b0;
    mem_req        = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    unique case (state)
      S_CMP: begin
        cache_cmp     = 1'b1;
        cache_write   = req_write;
        cache_tag     = req_tag;
        cache_index   = req_index;
        cache_word    = req_word;
        cache_data_in = req_wdata;
      end
      S_WB_RD: begin
        cache_tag   = victim_tag;
        cache_index = req_index;
        cache_word  = w;
      end
      S_WB_MEM: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {victim_tag, req_index, w};
        mem_wdata = buf_data;
      end
      S_FL_MEM: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, w};
      end
      S_FL_WR: begin
        cache_write    = 1'b1;
        cache_valid_in = 1'b1;
        cache_tag      = req_tag;
        cache_index    = req_index;
        cache_word     = w;
        cache_data_in  = buf_data;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        cpu_rdata = rdata_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // hit/miss judged on the first compare only; a dirty victim counts wherever it is evicted
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (state == S_CMP && acc_done) begin
      if (first_cmp) begin
        if (hit_ok) begin
          if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
        end else begin
          if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
      end
      if (!hit_ok && wb_need && wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural 2-way cache and main memory responders, flat golden memory
// for expected data, directed scenarios followed by randomized traffic.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_write;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        cache_enable, cache_cmp, cache_write, cache_valid_in;
  logic [4:0]  cache_tag, cache_tag_out;
  logic [3:0]  cache_index;
  logic [1:0]  cache_word;
  logic [15:0] cache_data_in, cache_data_out;
  logic        cache_hit, cache_dirty, cache_valid, cache_ack;
  logic        mem_req, mem_write, mem_ack;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cache_enable(cache_enable), .cache_cmp(cache_cmp), .cache_write(cache_write),
    .cache_tag(cache_tag), .cache_index(cache_index), .cache_word(cache_word),
    .cache_data_in(cache_data_in), .cache_valid_in(cache_valid_in),
    .cache_hit(cache_hit), .cache_dirty(cache_dirty), .cache_tag_out(cache_tag_out),
    .cache_data_out(cache_data_out), .cache_valid(cache_valid), .cache_ack(cache_ack),
`ifdef CACHE_CTRL_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
`endif
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  logic out_any;
  assign out_any = |{cpu_rdata, cpu_ready, cache_enable, cache_cmp, cache_write, cache_tag,
                     cache_index, cache_word, cache_data_in, cache_valid_in,
                     mem_req, mem_write, mem_addr, mem_wdata
`ifdef CACHE_CTRL_STATS_EN
                     , hit_count, miss_count, wb_count
`endif
                     };

  logic [29:0] cache_bus;
  logic [27:0] mem_bus;
  assign cache_bus = {cache_cmp, cache_write, cache_tag, cache_index, cache_word, cache_data_in, cache_valid_in};
  assign mem_bus   = {mem_write, mem_addr, mem_wdata};

  // responder knobs, written only by the main sequence
  int c_dly = 0, m_dly = 0;
  bit c_fix = 1'b1, m_fix = 1'b1;

  // backing memory content before any writeback
  function automatic logic [15:0] init_val(input logic [10:0] a);
    if (a == 11'b11101_0000_11) return 16'h0F0F;
    return {a[4:0], a} ^ 16'hA5C3;
  endfunction

  // ---------------- behavioural cache (environment) ----------------
  logic [15:0] cm_data [16][2][4];
  logic [4:0]  cm_tag  [16][2];
  logic        cm_vld  [16][2];
  logic        cm_drt  [16][2];
  logic        cm_sel  [16];
  logic        cm_ptr  [16];
  int          stab_err = 0, gap_err = 0;

  function automatic int victim_of(input int s);
    if (!cm_vld[s][0]) return 0;
    if (!cm_vld[s][1]) return 1;
    return int'(cm_ptr[s]);
  endfunction

  initial begin
    int cnt, s, v, hw;
    bit busy;
    logic [29:0] snap;
    cache_ack = 0; cache_hit = 0; cache_dirty = 0; cache_tag_out = 0; cache_data_out = 0; cache_valid = 0;
    busy = 0; cnt = 0; snap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cache_ack = 0; busy = 0;
        for (int i = 0; i < 16; i++) begin
          cm_sel[i] = 0; cm_ptr[i] = 0;
          for (int k = 0; k < 2; k++) begin cm_vld[i][k] = 0; cm_drt[i][k] = 0; cm_tag[i][k] = 0; end
        end
        // set 0 way 1 starts with a clean resident line
        cm_vld[0][1] = 1; cm_tag[0][1] = 5'b00010;
        for (int j = 0; j < 4; j++) cm_data[0][1][j] = init_val({5'b00010, 4'd0, 2'(j)});
      end else if (cache_ack) begin
        cache_ack = 0;
        if (cache_enable) gap_err++;
      end else if (cache_enable) begin
        if (!busy) begin
          busy = 1; snap = cache_bus;
          cnt = c_fix ? c_dly : int'($urandom_range(c_dly, 0));
        end else if (cache_bus !== snap) stab_err++;
        if (cnt == 0) begin
          s = int'(cache_index);
          if (cache_cmp) begin
            hw = -1;
            for (int k = 0; k < 2; k++) if (cm_vld[s][k] && cm_tag[s][k] == cache_tag) hw = k;
            if (hw >= 0) begin
              if (cache_write) begin cm_data[s][hw][cache_word] = cache_data_in; cm_drt[s][hw] = 1; end
              cache_hit = 1; cache_valid = 1; cache_dirty = cm_drt[s][hw];
              cache_tag_out = cm_tag[s][hw]; cache_data_out = cm_data[s][hw][cache_word];
            end else begin
              v = victim_of(s);
              if (cm_vld[s][0] && cm_vld[s][1]) cm_ptr[s] = ~cm_ptr[s];
              cm_sel[s] = v[0];
              cache_hit = 0; cache_valid = cm_vld[s][v]; cache_dirty = cm_drt[s][v];
              cache_tag_out = cm_tag[s][v]; cache_data_out = 16'h0;
            end
          end else begin
            v = int'(cm_sel[s]);
            if (cache_write) begin
              cm_data[s][v][cache_word] = cache_data_in; cm_tag[s][v] = cache_tag;
              cm_vld[s][v] = cache_valid_in; cm_drt[s][v] = 0;
            end
            cache_hit = 0; cache_valid = cm_vld[s][v]; cache_dirty = cm_drt[s][v];
            cache_tag_out = cm_tag[s][v]; cache_data_out = cm_data[s][v][cache_word];
          end
          cache_ack = 1; busy = 0;
        end else cnt--;
      end else if (busy) begin
        stab_err++; busy = 0;
      end
    end
  end

  // ---------------- main memory (environment) ----------------
  logic [15:0] mm_data [2048];
  bit          mm_wr   [2048];
  logic [10:0] wr_addr [1024];
  logic [15:0] wr_data [1024];
  logic [10:0] rd_addr [1024];
  int          wr_n = 0, rd_n = 0, mstab_err = 0;

  initial begin
    int mcnt;
    bit mbusy;
    logic [27:0] msnap;
    mem_ack = 0; mem_rdata = 0; mbusy = 0; mcnt = 0; msnap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 0; mbusy = 0;
      end else if (mem_ack) begin
        mem_ack = 0;
      end else if (mem_req) begin
        if (!mbusy) begin
          mbusy = 1; msnap = mem_bus;
          mcnt = m_fix ? m_dly : int'($urandom_range(m_dly, 0));
        end else if (mem_bus !== msnap) mstab_err++;
        if (mcnt == 0) begin
          if (mem_write) begin
            mm_data[mem_addr] = mem_wdata; mm_wr[mem_addr] = 1;
            if (wr_n < 1024) begin wr_addr[wr_n] = mem_addr; wr_data[wr_n] = mem_wdata; wr_n++; end
          end else begin
            mem_rdata = mm_wr[mem_addr] ? mm_data[mem_addr] : init_val(mem_addr);
            if (rd_n < 1024) begin rd_addr[rd_n] = mem_addr; rd_n++; end
          end
          mem_ack = 1; mbusy = 0;
        end else mcnt--;
      end else if (mbusy) begin
        mstab_err++; mbusy = 0;
      end
    end
  end

  // ---------------- reference and checking ----------------
  logic [15:0] gold [2048];
  int n_cmp = 0, n_bad = 0;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic wr, input logic [10:0] a, input logic [15:0] d,
                         input int exp_lat, input bit hold_done, output logic [15:0] rdat);
    int s, v, rd0, wr0, s0, m0, g0, lat;
    bit hitp, p_wb, got;
    logic [4:0] vtag;
    logic [15:0] exp_d;
    s = int'(a[5:2]); hitp = 0;
    for (int k = 0; k < 2; k++) if (cm_vld[s][k] && cm_tag[s][k] == a[10:6]) hitp = 1;
    v = victim_of(s);
    p_wb = !hitp && cm_vld[s][v] && cm_drt[s][v];
    vtag = cm_tag[s][v];
    if (hitp) exp_hit++; else exp_miss++;
    if (p_wb) exp_wb++;
    exp_d = wr ? 16'h0 : gold[a];
    rd0 = rd_n; wr0 = wr_n; s0 = stab_err; m0 = mstab_err; g0 = gap_err;
    cpu_req = 1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_req = 0; cpu_write = 1'($urandom); cpu_addr = 11'($urandom); cpu_wdata = 16'($urandom);
    lat = 1; got = 0; rdat = 16'hxxxx;
    while (!got && lat < 3000) begin
      if (cpu_ready) begin got = 1; rdat = cpu_rdata; end
      else begin @(negedge clk); lat++; end
    end
    chk("txn_done", 32'(got), 32'd1);
    chk("rdata", 32'(rdat), 32'(exp_d));
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    if (hold_done) begin
      cpu_req = 1; cpu_write = 0; cpu_addr = a;
      @(negedge clk);
      cpu_req = 0;
      chk("no_accept_in_done", 32'(cache_enable), 32'd0);
    end else @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 32'd0);
    chk("fill_reads", rd_n - rd0, hitp ? 0 : 4);
    chk("wb_writes", wr_n - wr0, p_wb ? 4 : 0);
    for (int i = 0; i < rd_n - rd0 && i < 4; i++)
      chk("fill_addr", 32'(rd_addr[rd0+i]), 32'({a[10:6], a[5:2], 2'(i)}));
    for (int i = 0; i < wr_n - wr0 && i < 4; i++) begin
      chk("wb_addr", 32'(wr_addr[wr0+i]), 32'({vtag, a[5:2], 2'(i)}));
      chk("wb_data", 32'(wr_data[wr0+i]), 32'(gold[{vtag, a[5:2], 2'(i)}]));
    end
    chk("cache_stable", stab_err - s0, 0);
    chk("mem_stable", mstab_err - m0, 0);
    chk("enable_gap", gap_err - g0, 0);
    if (wr) gold[a] = d;
  endtask

  initial begin
    logic [15:0] r;
    int base, w0;
    bit seen;
    rst = 1; cpu_req = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < 2048; i++) gold[i] = init_val(11'(i));
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(out_any), 32'd0);
    rst = 0;
    @(negedge clk);

    // reset in the middle of a refill
    m_fix = 1; m_dly = 2;
    cpu_req = 1; cpu_write = 0; cpu_addr = {5'b00111, 4'd5, 2'd1};
    @(negedge clk);
    cpu_req = 0;
    base = rd_n; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (mem_req && !mem_write && rd_n == base + 1) seen = 1;
      else @(negedge clk);
    end
    chk("midfill_reached", 32'(seen), 32'd1);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_outputs", 32'(out_any), 32'd0);
    end
    rst = 0;
    @(negedge clk);
    exp_hit = 0; exp_miss = 0; exp_wb = 0;

    // cold load, store hit, dirty-victim eviction
    c_fix = 1; c_dly = 0; m_fix = 1; m_dly = 0;
    run_txn(0, 11'b11101_0000_11, 16'h0, 0, 0, r);
    chk("cold_load_data", 32'(r), 32'h0F0F);
    base = rd_n; w0 = wr_n;
    run_txn(1, 11'b11101_0000_11, 16'hBEEF, 2, 1, r);
    chk("store_hit_no_mem", (rd_n - base) + (wr_n - w0), 0);
    w0 = wr_n;
    run_txn(0, 11'b00001_0000_11, 16'h0, 0, 0, r);
    chk("evict_first_addr", 32'(wr_addr[w0]), 32'(11'b11101_0000_00));
    chk("evict_word3_data", 32'(wr_data[w0+3]), 32'hBEEF);
`ifdef CACHE_CTRL_STATS_EN
    chk("hit_count", 32'(hit_count), 32'd1);
    chk("miss_count", 32'(miss_count), 32'd2);
    chk("wb_count", 32'(wb_count), 32'd1);
`endif

    // slow cache and memory handshakes
    c_fix = 1; c_dly = 3; m_fix = 1; m_dly = 5;
    run_txn(1, 11'b00001_0000_00, 16'h1234, 5, 0, r);
    run_txn(0, 11'b00110_0000_10, 16'h0, 0, 0, r);
    run_txn(0, 11'b00111_0000_01, 16'h0, 0, 0, r);

    // randomized traffic over a few tags and sets to force conflicts
    c_fix = 0; c_dly = 3; m_fix = 0; m_dly = 4;
    for (int t = 0; t < 60; t++)
      run_txn(1'($urandom), {3'b000, 2'($urandom), 3'b000, 1'($urandom), 2'($urandom)},
              16'($urandom), 0, 0, r);
`ifdef CACHE_CTRL_STATS_EN
    chk("hit_count_end", 32'(hit_count), 32'(exp_hit));
    chk("miss_count_end", 32'(miss_count), 32'(exp_miss));
    chk("wb_count_end", 32'(wb_count), 32'(exp_wb));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
